i2c_cfg_slave: RTL and testbench

//  I2C write-only responder emulating the WM8731 control port: the receive end of the
//  3-byte {dev_addr, word[15:8], word[7:0]} transfers issued by the codec config master.

---
 rtl/i2c_cfg_slave.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_cfg_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_slave.sv
// WM8731-style write-only I2C control-port responder: decodes {dev, word_hi, word_lo} into reg addr/data.
// Optional I2C_SLV_DEGLITCH_EN adds a 3-sample majority filter on SCL/SDA after the synchronisers.
module i2c_cfg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oREG_WR,
    output logic       oBUSY
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_BYTE_HI,
        S_ACK_HI,
        S_BYTE_LO,
        S_ACK_LO,
        S_IGNORE
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-2:0]   shift_q,    shift_d;
    logic [WORD_W-1:0]   word_q,     word_d;
    logic                sda_oe_q,   sda_oe_d;
    logic [6:0]          reg_addr_q, reg_addr_d;
    logic [8:0]          reg_data_q, reg_data_d;
    logic                reg_wr_q,   reg_wr_d;
    logic                busy_q,     busy_d;
    logic [1:0]          scl_sync_q, scl_sync_d;
    logic [1:0]          sda_sync_q, sda_sync_d;
    logic                scl_prev_q, scl_prev_d;
    logic                sda_prev_q, sda_prev_d;

    logic                scl_v;
    logic                sda_v;
    logic                scl_rise;
    logic                scl_fall;
    logic                bus_start;
    logic                bus_stop;
    logic [BYTE_W-1:0]   rx_byte;

`ifdef I2C_SLV_DEGLITCH_EN
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d;
    logic       sda_filt_q, sda_filt_d;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority over the current and two previous synced samples; a 1-cycle pulse never wins.
    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_filt_d = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_v = scl_filt_q;
    assign sda_v = sda_filt_q;
`else
    assign scl_v = scl_sync_q[1];
    assign sda_v = sda_sync_q[1];
`endif

    assign scl_rise  = scl_v & ~scl_prev_q;
    assign scl_fall  = ~scl_v & scl_prev_q;
    assign bus_start = scl_v & scl_prev_q & sda_prev_q & ~sda_v;
    assign bus_stop  = scl_v & scl_prev_q & ~sda_prev_q & sda_v;

    // Next-state and registered-output logic; START/STOP take priority over every state.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], I2C_SCLK};
        sda_sync_d = {sda_sync_q[0], I2C_SDAT};
        scl_prev_d = scl_v;
        sda_prev_d = sda_v;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        sda_oe_d   = sda_oe_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_wr_d   = 1'b0;
        busy_d     = busy_q;
        rx_byte    = {shift_q, sda_v};

        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (bus_stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE_HI, S_BYTE_LO: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            if (state_q == S_ADDR) begin
                                state_d = (rx_byte == {SLAVE_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                            end else if (state_q == S_BYTE_HI) begin
                                word_d[15:8] = rx_byte;
                                state_d      = S_ACK_HI;
                            end else begin
                                word_d[7:0] = rx_byte;
                                state_d     = S_ACK_LO;
                            end
                        end
                    end
                end
                // First fall pulls SDA low for the 9th clock, second fall releases it.
                S_ACK_A, S_ACK_HI, S_ACK_LO: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            case (state_q)
                                S_ACK_A:  state_d = S_BYTE_HI;
                                S_ACK_HI: state_d = S_BYTE_LO;
                                default: begin
                                    state_d    = S_IGNORE;
                                    reg_wr_d   = 1'b1;
                                    reg_addr_d = word_q[15:9];
                                    reg_data_d = word_q[8:0];
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            sda_oe_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            reg_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            sda_oe_q   <= sda_oe_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            reg_wr_q   <= reg_wr_d;
            busy_q     <= busy_d;
        end
    end

    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign oREG_ADDR = reg_addr_q;
    assign oREG_DATA = reg_data_q;
    assign oREG_WR   = reg_wr_q;
    assign oBUSY     = busy_q;

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Bench for i2c_cfg_slave: bit-banged I2C master, directed + random transfers vs. a transaction-level model.
module tb_i2c_cfg_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    wire        sda_w;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       reg_wr;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_w = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_cfg_slave dut (
        .iCLK      (clk),
        .iRST      (rst),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda_w),
        .oREG_ADDR (reg_addr),
        .oREG_DATA (reg_data),
        .oREG_WR   (reg_wr),
        .oBUSY     (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_count = 0;
    int          exp_pulses = 0;
    logic [6:0]  exp_addr = '0;
    logic [8:0]  exp_data = '0;
    logic [7:0]  xb [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && reg_wr) wr_count++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Also serves as repeated START when SCL is low.
    task automatic i2c_start();
        wait_clk(5); m_sda_low = 1'b0;
        wait_clk(5); scl = 1'b1;
        wait_clk(10); m_sda_low = 1'b1;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5); m_sda_low = 1'b1;
        wait_clk(5); scl = 1'b1;
        wait_clk(10); m_sda_low = 1'b0;
        wait_clk(10);
    endtask

    // glitch_bit >= 0 inserts a 1-iCLK SCL high pulse in that bit's low phase.
    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 0; i < 8; i++) begin
            wait_clk(5); m_sda_low = ~b[7-i];
            if (i == glitch_bit) begin
                wait_clk(2); scl = 1'b1;
                wait_clk(1); scl = 1'b0;
                wait_clk(2);
            end else begin
                wait_clk(5);
            end
            scl = 1'b1;
            wait_clk(10); scl = 1'b0;
        end
    endtask

    task automatic ack_clock(output logic acked);
        wait_clk(5); m_sda_low = 1'b0;
        wait_clk(5); scl = 1'b1;
        wait_clk(5); acked = (sda_w == 1'b0);
        wait_clk(5); scl = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        wait_clk(10);
        chk({tag, "_pulses"}, 32'(wr_count), 32'(exp_pulses));
        chk({tag, "_addr"}, 32'(reg_addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(reg_data), 32'(exp_data));
    endtask

    // Model: address byte ACKed iff it is the write address; next two bytes ACKed then NACK.
    task automatic run_xfer(input int n, input bit do_stop, input string tag);
        logic        acked;
        logic        addr_ok;
        logic [15:0] word;
        i2c_start();
        chk({tag, "_busy_start"}, 32'(busy), 32'(1));
        addr_ok = (xb[0] == 8'h34);
        for (int i = 0; i < n; i++) begin
            send_bits(xb[i], -1);
            ack_clock(acked);
            chk($sformatf("%s_ack%0d", tag, i), 32'(acked),
                32'((i == 0) ? addr_ok : (addr_ok && i < 3)));
        end
        if (addr_ok && n >= 3) begin
            word       = {xb[1], xb[2]};
            exp_pulses = exp_pulses + 1;
            exp_addr   = word[15:9];
            exp_data   = word[8:0];
        end
        if (do_stop) begin
            i2c_stop();
            chk({tag, "_busy_stop"}, 32'(busy), 32'(0));
        end
        check_outputs(tag);
    endtask

    initial begin
        logic       acked;
        logic [7:0] lo_exp;
        int         n;
        bit         st;

        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
        wait_clk(4);
        chk("reset_addr", 32'(reg_addr), 32'(0));
        chk("reset_data", 32'(reg_data), 32'(0));
        chk("reset_wr", 32'(reg_wr), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_sda", 32'(sda_w), 32'(1));
        rst = 1'b0;
        wait_clk(4);

        xb[0] = 8'h34; xb[1] = 8'h1E; xb[2] = 8'h00;
        run_xfer(3, 1'b1, "t1");
        xb[0] = 8'h34; xb[1] = 8'h01; xb[2] = 8'h7F;
        run_xfer(3, 1'b0, "t2a");
        xb[0] = 8'h34; xb[1] = 8'h04; xb[2] = 8'h79;
        run_xfer(3, 1'b1, "t2b");
        xb[0] = 8'h36; xb[1] = 8'h12; xb[2] = 8'h34;
        run_xfer(3, 1'b1, "t3a");
        xb[0] = 8'h35; xb[1] = 8'h12; xb[2] = 8'h34;
        run_xfer(3, 1'b1, "t3b");
        xb[0] = 8'h34; xb[1] = 8'h0E;
        run_xfer(2, 1'b1, "t4a");
        run_xfer(2, 1'b0, "t4b");
        xb[0] = 8'h34; xb[1] = 8'h0C; xb[2] = 8'h02;
        run_xfer(3, 1'b1, "t4c");
        xb[0] = 8'h34; xb[1] = 8'h12; xb[2] = 8'h34; xb[3] = 8'h56;
        run_xfer(4, 1'b1, "t5a");

        // Reset asserted while the slave holds the ACK after the high data byte.
        i2c_start();
        send_bits(8'h34, -1);
        ack_clock(acked);
        chk("rst_addr_ack", 32'(acked), 32'(1));
        send_bits(8'hA5, -1);
        wait_clk(5); m_sda_low = 1'b0;
        wait_clk(5);
        chk("rst_ack_hi_driven", 32'(sda_w), 32'(0));
        rst = 1'b1;
        #1;
        chk("rst_sda_released", 32'(sda_w), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_addr_clr", 32'(reg_addr), 32'(0));
        chk("rst_data_clr", 32'(reg_data), 32'(0));
        exp_addr = '0;
        exp_data = '0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        xb[0] = 8'h34; xb[1] = 8'hAB; xb[2] = 8'hCD;
        run_xfer(3, 1'b1, "t5b");

        // SCL glitch in bit 3 of the low byte: filtered build ignores it, plain build takes it as a bit.
        i2c_start();
        send_bits(8'h34, -1);
        ack_clock(acked);
        chk("gl_ack0", 32'(acked), 32'(1));
        send_bits(8'h5A, -1);
        ack_clock(acked);
        chk("gl_ack1", 32'(acked), 32'(1));
        send_bits(8'hB6, 3);
        ack_clock(acked);
`ifdef I2C_SLV_DEGLITCH_EN
        lo_exp = 8'hB6;
        chk("gl_ack2", 32'(acked), 32'(1));
`else
        lo_exp = 8'hBB;
        chk("gl_ack2", 32'(acked), 32'(0));
`endif
        i2c_stop();
        exp_pulses = exp_pulses + 1;
        exp_addr   = 7'h2D;
        exp_data   = {1'b0, lo_exp};
        check_outputs("glitch");

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    xb[0] = 8'h34;
                2:       xb[0] = ($urandom_range(0, 1) == 0) ? 8'h36 : 8'h35;
                default: xb[0] = 8'($urandom);
            endcase
            for (int k = 1; k < 5; k++) xb[k] = 8'($urandom);
            n  = $urandom_range(1, 4);
            st = (t == 19) ? 1'b1 : 1'($urandom_range(0, 1));
            run_xfer(n, st, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
